// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO bus responder: address-map region
// nibbles, the transaction FSM states and the region decoder.
package mio_pkg;

  // Address map, selected by Addr_in[31:28]
  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'hE;
  localparam logic [3:0] REG_CNT = 4'hF;

  // Transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } mio_state_t;

  // Decoded target of a transaction
  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_LED  = 2'd1,
    RGN_CNT  = 2'd2,
    RGN_NONE = 2'd3
  } mio_region_t;

  // Map the top address nibble onto a region; anything not listed is unmapped
  function automatic mio_region_t decode_region(input logic [3:0] nib);
    mio_region_t rgn;
    case (nib)
      REG_RAM: rgn = RGN_RAM;
      REG_LED: rgn = RGN_LED;
      REG_CNT: rgn = RGN_CNT;
      default: rgn = RGN_NONE;
    endcase
    return rgn;
  endfunction

endpackage

// File: rtl/mio_counter.sv
// 32-bit free-running counter with a synchronous load port. A load in the
// same cycle replaces the increment; the count wraps naturally at 2^32.
module mio_counter
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] ld_val,
  output logic [31:0] q
);

  logic [31:0] r_cnt;

  // Count every clock; load takes priority over the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ld) begin
      r_cnt <= ld_val;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign q = r_cnt;

endmodule

// File: rtl/mio_bus_responder.sv
// Target side of the CPU memory/IO bus. Accepts a request in IDLE, serves it
// from synchronous block RAM (fixed multi-cycle BUSY phase) or from the
// on-chip peripherals (LED/switch port, free-running counter), and returns
// read data together with a one-cycle MIO_ready acknowledge.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_LAT    = 2,
  parameter int LED_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CPU_MIO,
  input  logic                  MemRW,
  input  logic [31:0]           Addr_in,
  input  logic [31:0]           Wdata_in,
  output logic [31:0]           Rdata_out,
  output logic                  MIO_ready,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  input  logic [LED_W-1:0]      sw_in,
  output logic [LED_W-1:0]      led_out
);

  // Down-counter sized to hold RAM_LAT-1 (at least one bit)
  localparam int              LAT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LAT - 1);

  mio_state_t            r_state;
  logic [LAT_W-1:0]      r_lat;
  logic [RAM_ADDR_W-1:0] r_addr;
  logic [31:0]           r_data;
  logic                  r_we;
  mio_region_t           r_region;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_ram_we;
  logic [LED_W-1:0]      r_led;

  mio_region_t           w_region;
  logic [31:0]           w_periph_rdata;
  logic [31:0]           w_cnt;
  logic                  w_cnt_ld;
  logic                  w_addr_unused;

  // Byte-lane bits and RAM alias bits play no part in decoding
  assign w_addr_unused = ^{Addr_in[1:0], Addr_in[27:RAM_ADDR_W+2]};

  assign w_region = decode_region(Addr_in[31:28]);

  // Counter writes commit on the edge leaving ACK, like every peripheral write
  assign w_cnt_ld = (r_state == ST_ACK) && r_we && (r_region == RGN_CNT);

  mio_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .ld     (w_cnt_ld),
    .ld_val (r_data),
    .q      (w_cnt)
  );

  // Peripheral read mux, sampled straight from the live request at acceptance
  always_comb begin
    w_periph_rdata = '0;
    case (w_region)
      RGN_LED: w_periph_rdata = 32'(sw_in);
      RGN_CNT: w_periph_rdata = w_cnt;
      default: w_periph_rdata = '0;
    endcase
  end

  // Transaction FSM with latch registers, RAM strobe, read data and LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_lat    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_region <= RGN_RAM;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_ram_we <= 1'b0;
      r_led    <= '0;
    end else begin
      // Acknowledge and write strobe are single-cycle pulses
      r_ready  <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (CPU_MIO) begin
            r_addr   <= Addr_in[RAM_ADDR_W+1:2];
            r_data   <= Wdata_in;
            r_we     <= MemRW;
            r_region <= w_region;
            if (w_region == RGN_RAM) begin
              r_state  <= ST_BUSY;
              r_lat    <= LAT_INIT;
              r_ram_we <= MemRW;
            end else begin
              // Peripherals and unmapped space answer in a single cycle
              r_state <= ST_ACK;
              r_ready <= 1'b1;
              r_rdata <= MemRW ? 32'd0 : w_periph_rdata;
            end
          end
        end
        ST_BUSY: begin
          if (r_lat == '0) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            r_rdata <= r_we ? 32'd0 : ram_dout;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          if (r_we && (r_region == RGN_LED)) begin
            r_led <= r_data[LED_W-1:0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Rdata_out = r_rdata;
  assign MIO_ready = r_ready;
  assign ram_addr  = r_addr;
  assign ram_we    = r_ram_we;
  assign ram_din   = r_data;
  assign led_out   = r_led;

endmodule
